instr_dispatch_ctrl: RTL

- Sits downstream of the SPI instruction/data buffer.
- Queues decoded 17-byte commands (8-bit instruction + 128-bit data) tagged by class: camwrite, read or mem.
- Dispatches queued commands one at a time to the matching execution engine over a start/done handshake.
- Holds command outputs stable while the engine executes and reports queue/error status to the main control block.

---
 rtl/instr_dispatch_ctrl_if.sv | 38 +++
 rtl/instr_dispatch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch_ctrl_if.sv
// Dispatch bus: buffer-side command strobes, engine start/done handshake and status flags.
// master = buffer/engines/main-control side, slave = instr_dispatch_ctrl.
interface instr_dispatch_ctrl_if;
  logic [7:0]   instruction;
  logic [127:0] data;
  logic         valid_camwrite;
  logic         valid_read;
  logic         valid_mem;
  logic [7:0]   cmd_instr;
  logic [127:0] cmd_data;
  logic         cam_start;
  logic         rd_start;
  logic         mem_start;
  logic         cam_done;
  logic         rd_done;
  logic         mem_done;
  logic         busy;
  logic         fifo_empty;
  logic         fifo_full;
  logic         overflow_err;
  logic         multi_err;
  logic         timeout_err;
  logic         clr_err;

  modport master (
    output instruction, data, valid_camwrite, valid_read, valid_mem,
           cam_done, rd_done, mem_done, clr_err,
    input  cmd_instr, cmd_data, cam_start, rd_start, mem_start,
           busy, fifo_empty, fifo_full, overflow_err, multi_err, timeout_err
  );

  modport slave (
    input  instruction, data, valid_camwrite, valid_read, valid_mem,
           cam_done, rd_done, mem_done, clr_err,
    output cmd_instr, cmd_data, cam_start, rd_start, mem_start,
           busy, fifo_empty, fifo_full, overflow_err, multi_err, timeout_err
  );
endinterface

// File: rtl/instr_dispatch_ctrl.sv
// Queues class-tagged 17-byte commands and dispatches them one at a time over start/done.
// Define CMD_TIMEOUT_EN to abandon a command after TIMEOUT_CYCLES cycles in WAIT.
module instr_dispatch_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 sysClk,
  input  logic                 sysRst_n,
  instr_dispatch_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 + 8 + 128;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("instr_dispatch_ctrl: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES 1..65535");
  end

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

  state_t          state;
  logic [EW-1:0]   queue [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [EW-1:0]   pop_q;
  logic [1:0]      push_class, cmd_class;
  logic [7:0]      cmd_instr_q;
  logic [127:0]    cmd_data_q;
  logic            cam_start_q, rd_start_q, mem_start_q;
  logic            overflow_q, multi_q;
  logic            push_req, push_ok, pop, multi_hit, empty, full, done_sel;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign push_req  = bus.valid_camwrite | bus.valid_read | bus.valid_mem;
  assign push_ok   = push_req & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign multi_hit = (bus.valid_camwrite & bus.valid_read) | (bus.valid_camwrite & bus.valid_mem) |
                     (bus.valid_read & bus.valid_mem);

  // Simultaneous strobes collapse to one entry, camwrite > read > mem.
  always_comb begin
    push_class = 2'd0;
    if (bus.valid_camwrite)  push_class = 2'd0;
    else if (bus.valid_read) push_class = 2'd1;
    else if (bus.valid_mem)  push_class = 2'd2;
  end

  always_comb begin
    case (cmd_class)
      2'd0:    done_sel = bus.cam_done;
      2'd1:    done_sel = bus.rd_done;
      default: done_sel = bus.mem_done;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (push_ok) queue[wr_ptr] <= {push_class, bus.instruction, bus.data};
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pop_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pop_q  <= queue[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A strobe that finds the queue full is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
    end else if (bus.clr_err) begin
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      if (push_req && full) overflow_q <= 1'b1;
      if (multi_hit)        multi_q    <= 1'b1;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        timeout_q;
`endif

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state       <= IDLE;
      cmd_class   <= 2'd0;
      cmd_instr_q <= '0;
      cmd_data_q  <= '0;
      cam_start_q <= 1'b0;
      rd_start_q  <= 1'b0;
      mem_start_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      cam_start_q <= 1'b0;
      rd_start_q  <= 1'b0;
      mem_start_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      if (bus.clr_err) timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          {cmd_class, cmd_instr_q, cmd_data_q} <= pop_q;
          state <= ISSUE;
        end
        ISSUE: begin
          case (cmd_class)
            2'd0:    cam_start_q <= 1'b1;
            2'd1:    rd_start_q  <= 1'b1;
            default: mem_start_q <= 1'b1;
          endcase
`ifdef CMD_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
`ifdef CMD_TIMEOUT_EN
          // A done on the expiry edge takes precedence over the timeout.
          if (done_sel) begin
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
            if (!bus.clr_err) timeout_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`else
          if (done_sel) state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_instr    = cmd_instr_q;
  assign bus.cmd_data     = cmd_data_q;
  assign bus.cam_start    = cam_start_q;
  assign bus.rd_start     = rd_start_q;
  assign bus.mem_start    = mem_start_q;
  assign bus.busy         = (state != IDLE);
  assign bus.fifo_empty   = empty;
  assign bus.fifo_full    = full;
  assign bus.overflow_err = overflow_q;
  assign bus.multi_err    = multi_q;
`ifdef CMD_TIMEOUT_EN
  assign bus.timeout_err  = timeout_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif
endmodule
